// File: rtl/param_fifo.sv
// param_fifo: synchronous FIFO with count, almost/full/empty flags and sticky errors.
// Define PARAM_FIFO_FWFT_EN for first-word-fall-through output; default is a registered output.
module param_fifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 32,
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     rd,
  input  logic                     clr_err,
  output logic [WIDTH-1:0]         data_out,
  output logic [$clog2(DEPTH):0]   fifo_cnt,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_empty,
  output logic                     almost_full,
  output logic                     overflow,
  output logic                     underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic             rd_ok, wr_ok;
  assign empty        = fifo_cnt == '0;
  assign full         = fifo_cnt == CW'(DEPTH);
  assign almost_empty = fifo_cnt <= CW'(AE_LEVEL);
  assign almost_full  = fifo_cnt >= CW'(AF_LEVEL);
  assign rd_ok        = rd && !empty;
  assign wr_ok        = wr && (!full || rd_ok);
  always_ff @(posedge clk)
    if (wr_ok) mem[wr_ptr] <= data_in;
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      fifo_cnt  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      if (wr_ok && !rd_ok) fifo_cnt <= fifo_cnt + CW'(1);
      else if (rd_ok && !wr_ok) fifo_cnt <= fifo_cnt - CW'(1);
      // a new error in the same cycle as clr_err stays set
      overflow  <= (wr && !wr_ok) || (overflow && !clr_err);
      underflow <= (rd && empty) || (underflow && !clr_err);
    end
  end
`ifdef PARAM_FIFO_FWFT_EN
  assign data_out = empty ? '0 : mem[rd_ptr];
`else
  always_ff @(posedge clk) begin
    if (rst) data_out <= '0;
    else if (rd_ok) data_out <= mem[rd_ptr];
  end
`endif
endmodule

// File: tb/tb_param_fifo.sv
// tb_param_fifo: randomized and directed checks of param_fifo against a queue-based model.
module tb_param_fifo;
  localparam int D = 32;
  logic       clk = 1'b0, rst = 1'b1, wr = 1'b0, rd = 1'b0, clr_err = 1'b0;
  logic [7:0] data_in = '0, data_out;
  logic [5:0] fifo_cnt;
  logic       empty, full, almost_empty, almost_full, overflow, underflow;
  int         tests = 0, fails = 0;
  byte unsigned q[$];
  logic [7:0] m_dout = '0;
  bit         m_ovf = 0, m_unf = 0;

  param_fifo dut (
    .clk(clk), .rst(rst), .wr(wr), .data_in(data_in), .rd(rd), .clr_err(clr_err),
    .data_out(data_out), .fifo_cnt(fifo_cnt), .empty(empty), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input bit w, input bit r, input bit c, input bit rs, input logic [7:0] d);
    logic [7:0] exp_dout;
    wr = w; rd = r; clr_err = c; rst = rs; data_in = d;
    @(posedge clk);
    if (rs) begin
      q.delete(); m_dout = '0; m_ovf = 0; m_unf = 0;
    end else begin
      bit rok, wok;
      rok = r && q.size() != 0;
      wok = w && (q.size() < D || rok);
      m_ovf = (w && !wok) || (m_ovf && !c);
      m_unf = (r && q.size() == 0) || (m_unf && !c);
      if (rok) m_dout = q.pop_front();
      if (wok) q.push_back(d);
    end
`ifdef PARAM_FIFO_FWFT_EN
    exp_dout = q.size() != 0 ? q[0] : 8'h00;
`else
    exp_dout = m_dout;
`endif
    #1;
    check("fifo_cnt", 32'(fifo_cnt), q.size());
    check("empty", 32'(empty), 32'(q.size() == 0));
    check("full", 32'(full), 32'(q.size() == D));
    check("almost_empty", 32'(almost_empty), 32'(q.size() <= 4));
    check("almost_full", 32'(almost_full), 32'(q.size() >= D - 4));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("underflow", 32'(underflow), 32'(m_unf));
    check("data_out", 32'(data_out), 32'(exp_dout));
  endtask

  initial begin
    step(0, 0, 0, 1, 8'h00);
    step(1, 1, 1, 1, 8'h33);
    check("rst_cnt", 32'(fifo_cnt), 0);
    check("rst_empty", 32'(empty), 1);
    // fill to full, then one write too many
    for (int i = 1; i <= D; i++) step(1, 0, 0, 0, 8'(i));
    check("full_at_32", 32'(full), 1);
    check("cnt_at_32", 32'(fifo_cnt), 32);
    check("ovf_before", 32'(overflow), 0);
    step(1, 0, 0, 0, 8'hEE);
    check("ovf_33", 32'(overflow), 1);
    check("cnt_33", 32'(fifo_cnt), 32);
    for (int i = 1; i <= D; i++) begin
`ifdef PARAM_FIFO_FWFT_EN
      check("drain_fwft", 32'(data_out), i);
      step(0, 1, 0, 0, 8'h00);
`else
      step(0, 1, 0, 0, 8'h00);
      check("drain_reg", 32'(data_out), i);
`endif
    end
    check("drained_empty", 32'(empty), 1);
    step(0, 1, 0, 0, 8'h00);
    check("unf_extra", 32'(underflow), 1);
    step(0, 0, 1, 0, 8'h00);
    // full with simultaneous rd/wr for longer than one pointer lap
    for (int i = 0; i < D; i++) step(1, 0, 0, 0, 8'(8'h40 + i));
    for (int i = 0; i < 40; i++) step(1, 1, 0, 0, 8'($urandom));
    check("rw_full_cnt", 32'(fifo_cnt), 32);
    check("rw_full_ovf", 32'(overflow), 0);
    // empty with rd and wr together
    step(0, 0, 0, 1, 8'h00);
    step(1, 1, 0, 0, 8'hA5);
    check("rw_empty_cnt", 32'(fifo_cnt), 1);
    check("rw_empty_unf", 32'(underflow), 1);
    step(0, 1, 0, 0, 8'h00);
`ifndef PARAM_FIFO_FWFT_EN
    check("rw_empty_data", 32'(data_out), 32'hA5);
`endif
    // almost thresholds and clearing both errors
    step(0, 0, 0, 1, 8'h00);
    step(0, 1, 0, 0, 8'h00);
    for (int i = 0; i <= D; i++) step(1, 0, 0, 0, 8'($urandom));
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 8'h00);
    check("af_28", 32'(almost_full), 1);
    step(0, 1, 0, 0, 8'h00);
    check("af_27", 32'(almost_full), 0);
    for (int i = 0; i < 22; i++) step(0, 1, 0, 0, 8'h00);
    check("ae_5", 32'(almost_empty), 0);
    step(0, 1, 0, 0, 8'h00);
    check("ae_4", 32'(almost_empty), 1);
    step(0, 0, 1, 0, 8'h00);
    check("clr_ovf", 32'(overflow), 0);
    check("clr_unf", 32'(underflow), 0);
    // reset in the middle of a burst
    for (int i = 0; i < 10; i++) step(1, i[0], 0, 0, 8'($urandom));
    step(0, 1, 0, 0, 8'h00);
    step(1, 1, 0, 1, 8'h77);
    check("mid_rst_cnt", 32'(fifo_cnt), 0);
    check("mid_rst_empty", 32'(empty), 1);
    check("mid_rst_dout", 32'(data_out), 0);
    check("mid_rst_err", 32'({overflow, underflow}), 0);
    // random traffic with phases biased toward filling and draining
    for (int i = 0; i < 3000; i++) begin
      int bias;
      bias = ((i / 200) % 2 == 0) ? 75 : 25;
      step($urandom_range(99) < bias, $urandom_range(99) >= bias - 10,
           $urandom_range(19) == 0, $urandom_range(499) == 0, 8'($urandom));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/param_fifo.md
PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 32, number of entries (power of two, >=4).
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-4, count at or above which almost_full asserts.
REQ-004 SHALL have parameter AE_LEVEL, default 4, count at or below which almost_empty asserts.
REQ-005 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port wr  input  1  write request.
REQ-008 SHALL have port data_in  input  WIDTH  write data.
REQ-009 SHALL have port rd  input  1  read request.
REQ-010 SHALL have port clr_err  input  1  clears the sticky error flags.
REQ-011 SHALL have port data_out  output  WIDTH  read data.
REQ-012 SHALL have port fifo_cnt  output  $clog2(DEPTH)+1  number of occupied entries.
REQ-013 SHALL have port empty / full  output  1 each  fifo_cnt==0 / fifo_cnt==DEPTH.
REQ-014 SHALL have port almost_empty / almost_full  output  1 each  fifo_cnt<=AE_LEVEL / fifo_cnt>=AF_LEVEL.
REQ-015 SHALL have port overflow / underflow  output  1 each  sticky error flags.

Function
REQ-016 Storage SHALL be DEPTH x WIDTH; rd_ptr and wr_ptr SHALL be $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
REQ-017 Read accepted (rd_ok) SHALL be rd && !empty; write accepted (wr_ok) SHALL be wr && (!full || rd_ok).
REQ-018 On wr_ok, data_in SHALL be stored at wr_ptr and wr_ptr SHALL increment.
REQ-019 On rd_ok, rd_ptr SHALL increment.
REQ-020 fifo_cnt SHALL be +1 on wr_ok only, -1 on rd_ok only, and unchanged on both or neither.
REQ-021 When full with rd and wr both high, both SHALL be accepted; fifo_cnt stays DEPTH.
REQ-022 When empty with rd and wr both high, only the write SHALL be accepted; fifo_cnt becomes 1; underflow SHALL set.
REQ-023 All status flags SHALL be decoded combinationally from the registered fifo_cnt.
REQ-024 overflow SHALL set on the cycle after wr && !wr_ok; underflow SHALL set on the cycle after rd && empty.
REQ-025 Both error flags SHALL hold until clr_err or rst; when a set and clr_err coincide, set SHALL win.
REQ-026 A rejected write SHALL not alter memory, pointers or count; a rejected read SHALL not alter data_out.

Reset
REQ-027 While rst is high at a clock edge, rd_ptr, wr_ptr, fifo_cnt, data_out, overflow and underflow SHALL clear to 0; empty=1, almost_empty=1, full=0, almost_full=0.
REQ-028 rst SHALL take priority over any simultaneous rd, wr or clr_err; memory contents need not be cleared.

Configuration
REQ-029 Macro PARAM_FIFO_FWFT_EN SHALL select first-word-fall-through mode.
REQ-030 Without it: data_out SHALL be registered, loaded with mem[rd_ptr] one cycle after rd_ok, and otherwise held.
REQ-031 With it: data_out SHALL equal mem[rd_ptr] combinationally whenever !empty, rd SHALL act as pop acknowledge, and data_out SHALL be 0 when empty.

Verification
REQ-032 Reset, then write 0x01..0x20 (DEPTH=32): full=1 and fifo_cnt=32 after the 32nd write; a 33rd write sets overflow and leaves fifo_cnt at 32.
REQ-033 Drain the full FIFO: data_out = 0x01..0x20 in order, 1-cycle latency (0-cycle with FWFT); empty=1 after the last read; one extra rd sets underflow.
REQ-034 With FIFO full, hold rd=wr=1 for 40 cycles: fifo_cnt stays 32, pointers wrap, output order is preserved, and overflow stays 0.
REQ-035 With FIFO empty, assert rd=wr=1 with data 0xA5: fifo_cnt=1, underflow=1, and the next read returns 0xA5.
REQ-036 Fill to 28 then 27 entries: almost_full is 1 then 0; at 4 entries almost_empty=1, at 5 it is 0; clr_err pulse clears both error flags.
REQ-037 Assert rst mid-burst with wr=1 and rd=1: the next cycle shows fifo_cnt=0, empty=1, data_out=0, and error flags 0.
